// File: rtl/decode_stage.sv
// Instruction decode stage: combinational field extraction feeding a DEPTH-entry output FIFO.
// Optional performance counters are enabled by defining DECODE_PERF_EN.
module decode_stage #(
    parameter int IMM_W = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_instr,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [7:0]                 out_opcode,
    output logic [2:0]                 out_type,
    output logic [3:0]                 out_rde,
    output logic [3:0]                 out_rs1,
    output logic [3:0]                 out_rs2,
    output logic [3:0]                 out_func,
    output logic [23:0]                out_imm,
    output logic [IMM_W-1:0]           out_imm_sx,
    output logic                       out_illegal,
    output logic [$clog2(DEPTH):0]     occupancy
`ifdef DECODE_PERF_EN
    ,
    output logic [31:0]                perf_decoded,
    output logic [31:0]                perf_illegal
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    typedef struct packed {
        logic [7:0]       opcode;
        logic [2:0]       typ;
        logic [3:0]       rde;
        logic [3:0]       rs1;
        logic [3:0]       rs2;
        logic [3:0]       func;
        logic [23:0]      imm;
        logic [IMM_W-1:0] imm_sx;
        logic             illegal;
    } bundle_t;

    bundle_t          dec_f;
    bundle_t          dec;
    logic [23:0]      sx24;
    logic [IMM_W-1:0] sx_full;

    // Field extraction; every field starts at zero so unused fields never carry stale data.
    always_comb begin
        dec_f        = '0;
        sx24         = '0;
        dec_f.opcode = in_instr[7:0];
        case (in_instr[3:0])
            4'd0: begin
                dec_f.typ  = 3'd0;
                dec_f.imm  = {16'b0, in_instr[15:8]};
                sx24       = {{16{in_instr[15]}}, in_instr[15:8]};
                dec_f.func = in_instr[19:16];
                dec_f.rs2  = in_instr[23:20];
                dec_f.rs1  = in_instr[27:24];
                dec_f.rde  = in_instr[31:28];
            end
            4'd1: begin
                dec_f.typ  = 3'd1;
                dec_f.imm  = {12'b0, in_instr[19:8]};
                sx24       = {{12{in_instr[19]}}, in_instr[19:8]};
                dec_f.rs2  = in_instr[23:20];
                dec_f.rs1  = in_instr[27:24];
                dec_f.rde  = in_instr[31:28];
            end
            4'd2: begin
                dec_f.typ  = 3'd2;
                dec_f.imm  = {12'b0, in_instr[19:8]};
                sx24       = {{12{in_instr[19]}}, in_instr[19:8]};
                dec_f.func = in_instr[23:20];
                dec_f.rs1  = in_instr[27:24];
                dec_f.rde  = in_instr[31:28];
            end
            4'd3: begin
                dec_f.typ  = 3'd3;
                dec_f.imm  = {8'b0, in_instr[23:8]};
                sx24       = {{8{in_instr[23]}}, in_instr[23:8]};
                dec_f.rs1  = in_instr[27:24];
                dec_f.rde  = in_instr[31:28];
            end
            4'd4: begin
                dec_f.typ  = 3'd4;
                dec_f.imm  = {8'b0, in_instr[23:8]};
                sx24       = {{8{in_instr[23]}}, in_instr[23:8]};
                dec_f.func = in_instr[27:24];
                dec_f.rde  = in_instr[31:28];
            end
            4'd5: begin
                dec_f.typ  = 3'd5;
                dec_f.imm  = {4'b0, in_instr[27:8]};
                sx24       = {{4{in_instr[27]}}, in_instr[27:8]};
                dec_f.func = in_instr[31:28];
            end
            4'd6: begin
                dec_f.typ  = 3'd6;
                dec_f.imm  = in_instr[31:8];
                sx24       = in_instr[31:8];
            end
            default: begin
                dec_f.illegal = 1'b1;
            end
        endcase
    end

    generate
        if (IMM_W > 24) begin : g_sx_wide
            assign sx_full = {{(IMM_W-24){sx24[23]}}, sx24};
        end else begin : g_sx_narrow
            assign sx_full = sx24;
        end
    endgenerate

    always_comb begin
        dec        = dec_f;
        dec.imm_sx = sx_full;
    end

    // Output queue
    bundle_t          mem_q [DEPTH];
    bundle_t          mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] occ_q, occ_d;
    logic             push;
    logic             pop;
    bundle_t          head;

    assign in_ready  = (occ_q < DEPTH_C);
    assign out_valid = (occ_q != '0);
    assign occupancy = occ_q;
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (push) begin
            mem_d[wr_ptr_q] = dec;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   occ_d = occ_q + CNT_ONE;
                2'b01:   occ_d = occ_q - CNT_ONE;
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Head is masked so the outputs read zero whenever the queue is empty.
    always_comb begin
        head = out_valid ? mem_q[rd_ptr_q] : '0;
    end

    assign out_opcode  = head.opcode;
    assign out_type    = head.typ;
    assign out_rde     = head.rde;
    assign out_rs1     = head.rs1;
    assign out_rs2     = head.rs2;
    assign out_func    = head.func;
    assign out_imm     = head.imm;
    assign out_imm_sx  = head.imm_sx;
    assign out_illegal = head.illegal;

`ifdef DECODE_PERF_EN
    logic [31:0] perf_dec_q, perf_dec_d;
    logic [31:0] perf_ill_q, perf_ill_d;

    // Saturating counters; flush leaves them untouched.
    always_comb begin
        perf_dec_d = perf_dec_q;
        perf_ill_d = perf_ill_q;
        if (push && (perf_dec_q != 32'hFFFF_FFFF)) begin
            perf_dec_d = perf_dec_q + 32'd1;
        end
        if (push && dec.illegal && (perf_ill_q != 32'hFFFF_FFFF)) begin
            perf_ill_d = perf_ill_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_dec_q <= '0;
            perf_ill_q <= '0;
        end else begin
            perf_dec_q <= perf_dec_d;
            perf_ill_q <= perf_ill_d;
        end
    end

    assign perf_decoded = perf_dec_q;
    assign perf_illegal = perf_ill_q;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Directed testbench for decode_stage: format decode, queue ordering, flush and async reset.
module tb_decode_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_opcode;
    logic [2:0]  out_type;
    logic [3:0]  out_rde;
    logic [3:0]  out_rs1;
    logic [3:0]  out_rs2;
    logic [3:0]  out_func;
    logic [23:0] out_imm;
    logic [31:0] out_imm_sx;
    logic        out_illegal;
    logic [1:0]  occupancy;
`ifdef DECODE_PERF_EN
    logic [31:0] perf_decoded;
    logic [31:0] perf_illegal;
`endif

    int n_checks;
    int n_errors;
    int n_push;
    int n_ill;

    decode_stage #(.IMM_W(32), .DEPTH(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_opcode  (out_opcode),
        .out_type    (out_type),
        .out_rde     (out_rde),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_func    (out_func),
        .out_imm     (out_imm),
        .out_imm_sx  (out_imm_sx),
        .out_illegal (out_illegal),
        .occupancy   (occupancy)
`ifdef DECODE_PERF_EN
        ,
        .perf_decoded(perf_decoded),
        .perf_illegal(perf_illegal)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] instr);
        in_valid = 1'b1;
        in_instr = instr;
        tick();
        in_valid = 1'b0;
        n_push++;
        if (instr[3:0] > 4'd6) n_ill++;
        $display("push 0x%08h occupancy=%0d", instr, occupancy);
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        $display("pop  occupancy=%0d", occupancy);
    endtask

    task automatic check_head(input string tag, input logic [7:0] opc, input logic [2:0] typ,
                              input logic [3:0] rde, input logic [3:0] rs1, input logic [3:0] rs2,
                              input logic [3:0] func, input logic [23:0] imm,
                              input logic [31:0] sx, input logic ill);
        chk({tag, ".valid"},   64'(out_valid),   64'(1'b1));
        chk({tag, ".opcode"},  64'(out_opcode),  64'(opc));
        chk({tag, ".type"},    64'(out_type),    64'(typ));
        chk({tag, ".rde"},     64'(out_rde),     64'(rde));
        chk({tag, ".rs1"},     64'(out_rs1),     64'(rs1));
        chk({tag, ".rs2"},     64'(out_rs2),     64'(rs2));
        chk({tag, ".func"},    64'(out_func),    64'(func));
        chk({tag, ".imm"},     64'(out_imm),     64'(imm));
        chk({tag, ".imm_sx"},  64'(out_imm_sx),  64'(sx));
        chk({tag, ".illegal"}, 64'(out_illegal), 64'(ill));
    endtask

    task automatic check_empty(input string tag);
        chk({tag, ".occ"},      64'(occupancy),  64'd0);
        chk({tag, ".valid"},    64'(out_valid),  64'd0);
        chk({tag, ".in_ready"}, 64'(in_ready),   64'd1);
        chk({tag, ".opcode0"},  64'(out_opcode), 64'd0);
        chk({tag, ".imm0"},     64'(out_imm),    64'd0);
        chk({tag, ".sx0"},      64'(out_imm_sx), 64'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        n_push    = 0;
        n_ill     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'h0;
        flush     = 1'b0;
        out_ready = 1'b0;

        #3;
        check_empty("reset");
        #10;
        rst_n = 1'b1;
        tick();

        // One word per format, each popped before the next.
        push_one(32'hA3B1_2340);
        chk("E.occ", 64'(occupancy), 64'd1);
        check_head("E", 8'h40, 3'd0, 4'hA, 4'h3, 4'hB, 4'h1, 24'h000023, 32'h0000_0023, 1'b0);
        pop_one();
        check_empty("E.popped");

        push_one(32'h12F0_0006);
        check_head("U", 8'h06, 3'd6, 4'h0, 4'h0, 4'h0, 4'h0, 24'h12F000, 32'h0012_F000, 1'b0);
        pop_one();
        push_one(32'h0080_0003);
        check_head("I", 8'h03, 3'd3, 4'h0, 4'h0, 4'h0, 4'h0, 24'h008000, 32'hFFFF_8000, 1'b0);
        pop_one();
        push_one(32'h5678_9AB1);
        check_head("R", 8'hB1, 3'd1, 4'h5, 4'h6, 4'h7, 4'h0, 24'h00089A, 32'hFFFF_F89A, 1'b0);
        pop_one();
        push_one(32'h1234_5672);
        check_head("M", 8'h72, 3'd2, 4'h1, 4'h2, 4'h0, 4'h3, 24'h000456, 32'h0000_0456, 1'b0);
        pop_one();
        push_one(32'h9ABC_DE04);
        check_head("F", 8'h04, 3'd4, 4'h9, 4'h0, 4'h0, 4'hA, 24'h00BCDE, 32'hFFFF_BCDE, 1'b0);
        pop_one();
        push_one(32'h7654_3215);
        check_head("B", 8'h15, 3'd5, 4'h0, 4'h0, 4'h0, 4'h7, 24'h065432, 32'h0006_5432, 1'b0);
        pop_one();
        push_one(32'hFFFF_FF0F);
        check_head("ILL15", 8'h0F, 3'd0, 4'h0, 4'h0, 4'h0, 4'h0, 24'h000000, 32'h0000_0000, 1'b1);
`ifdef DECODE_PERF_EN
        chk("perf_illegal.1", 64'(perf_illegal), 64'(n_ill));
`endif
        pop_one();
        push_one(32'h1234_5677);
        check_head("ILL7", 8'h77, 3'd0, 4'h0, 4'h0, 4'h0, 4'h0, 24'h000000, 32'h0000_0000, 1'b1);
        pop_one();
`ifdef DECODE_PERF_EN
        chk("perf_decoded", 64'(perf_decoded), 64'(n_push));
        chk("perf_illegal.2", 64'(perf_illegal), 64'(n_ill));
`endif

        // Fill to DEPTH with consumer stalled; third word must be held off.
        in_valid = 1'b1;
        in_instr = 32'h1111_1110;
        tick();
        chk("fill1.occ", 64'(occupancy), 64'd1);
        chk("fill1.in_ready", 64'(in_ready), 64'd1);
        in_instr = 32'h2222_2221;
        tick();
        chk("fill2.occ", 64'(occupancy), 64'd2);
        chk("fill2.in_ready", 64'(in_ready), 64'd0);
        in_instr = 32'h3333_3332;
        tick();
        chk("fill3.occ", 64'(occupancy), 64'd2);
        chk("fill3.head", 64'(out_opcode), 64'h10);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("drain1.occ", 64'(occupancy), 64'd1);
        chk("drain1.head", 64'(out_opcode), 64'h21);
        chk("drain1.rde", 64'(out_rde), 64'h2);
        tick();
        chk("drain2.occ", 64'(occupancy), 64'd0);
        chk("drain2.valid", 64'(out_valid), 64'd0);
        out_ready = 1'b0;
        $display("fifo fill/drain done occupancy=%0d", occupancy);

        // Simultaneous push and pop at occupancy 1.
        push_one(32'h1111_1110);
        in_valid  = 1'b1;
        in_instr  = 32'h2222_2221;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("pushpop.occ", 64'(occupancy), 64'd1);
        chk("pushpop.head", 64'(out_opcode), 64'h21);
        pop_one();
        chk("pushpop.drained", 64'(occupancy), 64'd0);

        // Flush with a full queue and concurrent push/pop.
        push_one(32'h1111_1110);
        push_one(32'h2222_2221);
        chk("preflush.occ", 64'(occupancy), 64'd2);
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'h3333_3332;
        out_ready = 1'b1;
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        $display("flush occupancy=%0d", occupancy);
        check_empty("flush");
        push_one(32'h3333_3332);
        chk("postflush.occ", 64'(occupancy), 64'd1);
        chk("postflush.head", 64'(out_opcode), 64'h32);
        chk("postflush.rs1", 64'(out_rs1), 64'h3);

        // Asynchronous reset between edges with one entry queued.
        #2;
        rst_n = 1'b0;
        #1;
        $display("async reset occupancy=%0d", occupancy);
        check_empty("areset");
`ifdef DECODE_PERF_EN
        chk("areset.perf", 64'(perf_decoded), 64'd0);
`endif
        #1;
        rst_n = 1'b1;
        tick();
        push_one(32'hA3B1_2340);
        check_head("post_reset", 8'h40, 3'd0, 4'hA, 4'h3, 4'hB, 4'h1, 24'h000023, 32'h0000_0023, 1'b0);
        chk("post_reset.occ", 64'(occupancy), 64'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter IMM_W, default 32, width of sign-extended immediate output (>=24).
REQ-002 Parameter DEPTH, default 2, output queue entries (power of two, >=2).
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  instruction word present.
REQ-006 in_ready  output  1  stage can accept a word this cycle.
REQ-007 in_instr  input  32  raw instruction.
REQ-008 flush  input  1  discard all queued and incoming entries.
REQ-009 out_valid  output  1  decoded bundle at queue head.
REQ-010 out_ready  input  1  consumer takes head this cycle.
REQ-011 out_opcode/out_type/out_rde/out_rs1/out_rs2/out_func  output  8/3/4/4/4/4  decoded fields.
REQ-012 out_imm  output  24  raw immediate, zero-extended.
REQ-013 out_imm_sx  output  IMM_W  immediate sign-extended from its format's top bit.
REQ-014 out_illegal  output  1  type code unrecognised.
REQ-015 occupancy  output  clog2(DEPTH)+1  queued entry count.

Function
REQ-016 Type code = in_instr[3:0]; opcode = in_instr[7:0]; codes 0..6 = E,R,M,I,F,B,U; 7..15 set illegal, all fields except opcode zero.
REQ-017 E: imm[15:8] (8b), func[19:16], rs2[23:20], rs1[27:24], rde[31:28].
REQ-018 R: imm[19:8] (12b), rs2[23:20], rs1[27:24], rde[31:28].
REQ-019 M: imm[19:8] (12b), func[23:20], rs1[27:24], rde[31:28].
REQ-020 I: imm[23:8] (16b), rs1[27:24], rde[31:28]; F: imm[23:8] (16b), func[27:24], rde[31:28].
REQ-021 B: imm[27:8] (20b), func[31:28]; U: imm[31:8] (24b).
REQ-022 Fields unused by a format shall be zero, never held from a prior instruction.
REQ-023 Decode is combinational on in_instr; the decoded bundle is written into a DEPTH-entry FIFO on push (in_valid & in_ready & !flush).
REQ-024 in_ready = (occupancy < DEPTH); no push while full even if pop occurs same cycle.
REQ-025 Pop = out_valid & out_ready; out_* shows head entry; out_valid = (occupancy != 0).
REQ-026 Latency: word pushed at edge N is visible on out_* after edge N when queue was empty (1 cycle).
REQ-027 Simultaneous push and pop with 0<occupancy<DEPTH: occupancy unchanged, order preserved.
REQ-028 Read/write pointers wrap modulo DEPTH; occupancy never exceeds DEPTH nor underflows.
REQ-029 flush: at next edge occupancy=0, pointers=0; concurrent push and pop are ignored.
REQ-030 out_* data shall be zero whenever out_valid is 0.

Reset
REQ-031 rst_n low asynchronously clears pointers, occupancy, out_valid and all out_* to 0; in_ready=1 while occupancy=0.
REQ-032 Reset mid-transfer discards all entries; first push after rst_n release behaves as REQ-026.

Configuration
REQ-033 Macro DECODE_PERF_EN defined: adds outputs perf_decoded (32) and perf_illegal (32), counting pushes and illegal pushes, saturating at 2^32-1, cleared by reset, not by flush.
REQ-034 Macro DECODE_PERF_EN undefined: these ports and counters do not exist; all other behaviour identical.

Verification
REQ-035 Push 0xA3B1_2340 (type 0, E) into empty queue -> next cycle out_valid=1, rde=A, rs1=3, rs2=B, func=1, imm=0x23, imm_sx=0x0000_0023.
REQ-036 Push 0x12F0_0006 (U) -> imm=0x12F000, imm_sx=0x0012_F000; push 0x0080_0003 (I) -> rde=0, rs1=0, imm=0x8000, imm_sx=0xFFFF_8000.
REQ-037 Push 0xFFFF_FF0F -> out_illegal=1, opcode=0x0F, other fields 0; with DECODE_PERF_EN perf_illegal increments by 1.
REQ-038 DEPTH=2, out_ready=0, push 3 words -> in_ready=0 after 2nd, 3rd held; release out_ready -> words emerge in order, occupancy 2,1,0.
REQ-039 Queue holding 2 entries, assert flush with in_valid=1 -> next cycle occupancy=0, out_valid=0, nothing pushed.
REQ-040 Assert rst_n=0 between edges with 1 entry queued -> out_valid falls immediately, in_ready=1.
